hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage RV32I pipeline.
- Drives the IF stage's `stop` input (PC hold) and the hold/flush controls of the IF/ID and ID/EX pipeline registers.
- Resolves load-use hazards, taken jump/branch squashes, data-memory wait states, and halt/resume on ECALL/EBREAK.
- Keeps saturating performance counters of stall and flush cycles.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, hazard-controller state encoding, load-use helper
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // x0 is hard-wired zero, so a load targeting it can never feed a consumer
    function automatic logic load_use(
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_rd,
        input logic             use_rs1,
        input logic [REG_W-1:0] rs1,
        input logic             use_rs2,
        input logic [REG_W-1:0] rs2
    );
        return ex_mem_read && (ex_rd != '0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush scheduler for the 5-stage RV32I pipeline
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_jump,
    input  logic             ex_halt,
    input  logic             mem_busy,
    input  logic             resume,
    output logic             pc_stop,
    output logic             ifid_stop,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW_RAW = $clog2(DRAIN_CYCLES + 1);
    localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    state_t        r_state;
    logic [DW-1:0] r_drain;
    logic          w_load_use;

    assign w_load_use = load_use(ex_mem_read, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!mem_busy && ex_halt) begin
                        r_state <= ST_DRAIN;
                        r_drain <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // A count of 0 also exits so a zero-length drain cannot lock up
                    if (!mem_busy) begin
                        if (r_drain <= DW'(1)) begin
                            r_state <= ST_HALT;
                            r_drain <= '0;
                        end else begin
                            r_drain <= r_drain - DW'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_drain <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_stop    = 1'b0;
        ifid_stop  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        freeze     = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        freeze    = 1'b1;
                        pc_stop   = 1'b1;
                        ifid_stop = 1'b1;
                    end else if (ex_halt) begin
                        pc_stop    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ex_jump) begin
                        // A coincident load-use belongs to the wrong path and is dropped
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_stop    = 1'b1;
                        ifid_stop  = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_stop    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    freeze     = mem_busy;
                end
                ST_HALT: begin
                    freeze    = 1'b1;
                    pc_stop   = 1'b1;
                    ifid_stop = 1'b1;
                    halted    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_stop),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ifid_flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_jump, ex_halt, mem_busy, resume;

    logic        pc_stop, ifid_stop, ifid_flush, idex_flush, freeze, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_stop, s_ifid_stop, s_ifid_flush, s_idex_flush, s_freeze, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode 0 running, 1 draining, 2 halted
    int m_mode, m_left, m_stall, m_flush;
    bit e_pc, e_ifs, e_iff, e_idf, e_frz, e_hlt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_jump(ex_jump), .ex_halt(ex_halt),
        .mem_busy(mem_busy), .resume(resume), .pc_stop(pc_stop),
        .ifid_stop(ifid_stop), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(DRAIN)) dut_small (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_jump(ex_jump), .ex_halt(ex_halt),
        .mem_busy(mem_busy), .resume(resume), .pc_stop(s_pc_stop),
        .ifid_stop(s_ifid_stop), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .freeze(s_freeze), .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                          input bit mr, input bit j, input bit h, input bit mb, input bit res);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = 5'(rd);
        ex_mem_read = mr; ex_jump = j; ex_halt = h; mem_busy = mb; resume = res;
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        {e_pc, e_ifs, e_iff, e_idf, e_frz, e_hlt} = '0;
        if (rst) return;
        if (m_mode == 0) begin
            if (mem_busy)     {e_frz, e_pc, e_ifs} = 3'b111;
            else if (ex_halt) {e_pc, e_iff, e_idf} = 3'b111;
            else if (ex_jump) {e_iff, e_idf} = 2'b11;
            else if (lu)      {e_pc, e_ifs, e_idf} = 3'b111;
        end else if (m_mode == 1) begin
            {e_pc, e_iff, e_idf} = 3'b111;
            e_frz = mem_busy;
        end else begin
            {e_frz, e_pc, e_ifs, e_hlt} = 4'b1111;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            model_reset();
            return;
        end
        if (e_pc)  m_stall++;
        if (e_iff) m_flush++;
        if (m_mode == 0) begin
            if (!mem_busy && ex_halt) begin m_mode = 1; m_left = DRAIN; end
        end else if (m_mode == 1) begin
            if (!mem_busy) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end else if (resume) begin
            m_mode = 0;
        end
    endtask

    // Entered just after a negedge with inputs applied; returns at the next negedge
    task automatic cycle(input string tag);
        #1;
        model_eval();
        check({tag, ".pc_stop"},    pc_stop,    e_pc);
        check({tag, ".ifid_stop"},  ifid_stop,  e_ifs);
        check({tag, ".ifid_flush"}, ifid_flush, e_iff);
        check({tag, ".idex_flush"}, idex_flush, e_idf);
        check({tag, ".freeze"},     freeze,     e_frz);
        check({tag, ".halted"},     halted,     e_hlt);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check({tag, ".stall_cnt"},   stall_cnt,   (m_stall > 65535) ? 65535 : m_stall);
        check({tag, ".flush_cnt"},   flush_cnt,   (m_flush > 65535) ? 65535 : m_flush);
        check({tag, ".stall_cnt4"}, s_stall_cnt, (m_stall > 15) ? 15 : m_stall);
        check({tag, ".flush_cnt4"}, s_flush_cnt, (m_flush > 15) ? 15 : m_flush);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        cycle("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Load-use bubble lasts exactly one cycle
        set_in(5, 0, 1, 0, 5, 1, 0, 0, 0, 0); cycle("lu");
        set_in(5, 0, 1, 0, 5, 0, 0, 0, 0, 0); cycle("lu_after");
        check("lu_stall_total", stall_cnt, 1);

        do_reset();
        set_in(0, 0, 1, 0, 0, 1, 0, 0, 0, 0); cycle("x0");
        set_in(1, 7, 1, 0, 7, 1, 0, 0, 0, 0); cycle("unused_rs2");
        check("x0_stall_total", stall_cnt, 0);

        do_reset();
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0); cycle("jump_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("jump_after");
        check("jump_flush_total", flush_cnt, 1);
        check("jump_stall_total", stall_cnt, 0);

        do_reset();
        set_in(5, 0, 1, 0, 5, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle("busy_lu");
        set_in(5, 0, 1, 0, 5, 1, 0, 0, 0, 0); cycle("busy_then_lu");
        set_in(5, 0, 1, 0, 5, 0, 0, 0, 0, 0); cycle("busy_done");
        check("busy_stall_total", stall_cnt, 4);

        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("halt_pulse");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 10; i++) begin
            #1 check("halt_rise", halted, (i >= 1 + DRAIN) ? 1 : 0);
            cycle("halt_wait");
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("resume");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("resume_fall", halted, 0);
        cycle("after_resume");

        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("halt2");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("halt2_wait");
        #2 rst = 1'b1;
        #1;
        check("rst_halted", halted, 0);
        check("rst_pc_stop", pc_stop, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cycle("saturate");
        check("sat_small", s_stall_cnt, 15);
        check("sat_wide", stall_cnt, 20);

        // Small register range keeps index collisions frequent
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
            rst = ($urandom_range(0, 199) == 0);
            cycle("rand");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
